// File: rtl/sprite_compositor.sv
// sprite_compositor: per-frame sprite motion plus pixel overlay for a VGA stream.
// Holds NUM_SPRITES top-left positions, steps them once per frame from direction
// requests, issues sprite-local image RAM addresses, and composites the returned
// sprite colours over the background (sprite 0 on top, TRANSPARENT_KEY is see-through).
// Pixel latency from x_i/y_i to vga_rgb_o is MEM_LATENCY+2 cycles, one pixel per clock.
// Build option: define SPRITE_COLLISION_EN to add per-frame opaque-overlap detection on
// collide_mask_o; without it collide_mask_o is tied low and no accumulator is built.
module sprite_compositor #(
  parameter int unsigned NUM_SPRITES     = 2,
  parameter int unsigned SPRITE_SIZE     = 64,
  parameter int unsigned STEP            = 3,
  parameter int unsigned VIDEO_WIDTH     = 640,
  parameter int unsigned VIDEO_HEIGHT    = 480,
  parameter int unsigned MEM_LATENCY     = 2,
  parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F,
  localparam int unsigned AW             = $clog2(SPRITE_SIZE * SPRITE_SIZE)
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic [9:0]                x_i,
  input  logic [9:0]                y_i,
  input  logic                      active_i,
  input  logic                      screen_end_i,
  input  logic [NUM_SPRITES-1:0]    move_up_i,
  input  logic [NUM_SPRITES-1:0]    move_down_i,
  input  logic [NUM_SPRITES-1:0]    move_left_i,
  input  logic [NUM_SPRITES-1:0]    move_right_i,
  output logic [NUM_SPRITES*AW-1:0] spr_addr_o,
  input  logic [NUM_SPRITES*12-1:0] spr_color_i,
  input  logic [11:0]               bg_color_i,
  output logic [11:0]               vga_rgb_o,
  output logic [NUM_SPRITES*10-1:0] pos_x_o,
  output logic [NUM_SPRITES*10-1:0] pos_y_o,
  output logic [NUM_SPRITES-1:0]    collide_mask_o
);

  // Sprite edge is a power of two, so the local address is just {row, column}.
  localparam int unsigned SW      = $clog2(SPRITE_SIZE);
  localparam logic [11:0] SizeW   = 12'(SPRITE_SIZE);
  localparam logic [11:0] StepW   = 12'(STEP);
  localparam logic [11:0] WidthW  = 12'(VIDEO_WIDTH);
  localparam logic [11:0] HeightW = 12'(VIDEO_HEIGHT);
  localparam logic [10:0] SizeP   = 11'(SPRITE_SIZE);
  localparam logic [9:0]  StepP   = 10'(STEP);

  // One-axis move: a blocked or contradictory request leaves the position untouched.
  function automatic logic [9:0] step_axis(input logic [9:0]  p,
                                           input logic        inc,
                                           input logic        dec,
                                           input logic [11:0] limit);
    logic [9:0] r;
    r = p;
    if (inc && !dec && (({2'b00, p} + SizeW + StepW) < limit)) begin
      r = p + StepP;
    end else if (dec && !inc && ({2'b00, p} >= StepW)) begin
      r = p - StepP;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Frame tick
  // ---------------------------------------------------------------------------
  logic screen_end_q;
  logic tick;

  assign tick = screen_end_i & ~screen_end_q;

  // Registered copy of screen_end for rising-edge detection.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      screen_end_q <= 1'b0;
    end else begin
      screen_end_q <= screen_end_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Sprite positions
  // ---------------------------------------------------------------------------
  logic [9:0] pos_x_q [NUM_SPRITES];
  logic [9:0] pos_x_d [NUM_SPRITES];
  logic [9:0] pos_y_q [NUM_SPRITES];
  logic [9:0] pos_y_d [NUM_SPRITES];

  // Next positions: only the frame tick moves sprites, so a frame never tears.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      pos_x_d[i] = pos_x_q[i];
      pos_y_d[i] = pos_y_q[i];
      if (tick) begin
        pos_x_d[i] = step_axis(pos_x_q[i], move_right_i[i], move_left_i[i], WidthW);
        pos_y_d[i] = step_axis(pos_y_q[i], move_down_i[i], move_up_i[i], HeightW);
      end
    end
  end

  // Position registers; sprites start spaced two sprite widths apart along the top.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pos_x_q[i] <= 10'(16 + i * 2 * SPRITE_SIZE);
        pos_y_q[i] <= 10'd16;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pos_x_q[i] <= pos_x_d[i];
        pos_y_q[i] <= pos_y_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: hit test and sprite-local address
  // ---------------------------------------------------------------------------
  logic [NUM_SPRITES-1:0] hit_d;
  logic [9:0]             dx [NUM_SPRITES];
  logic [9:0]             dy [NUM_SPRITES];
  logic [AW-1:0]          spr_addr_d [NUM_SPRITES];
  logic [AW-1:0]          spr_addr_q [NUM_SPRITES];

  // Bounding-box test per sprite; the address is forced to zero off-sprite.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      hit_d[i] = (x_i >= pos_x_q[i]) && ({1'b0, x_i} < ({1'b0, pos_x_q[i]} + SizeP)) &&
                 (y_i >= pos_y_q[i]) && ({1'b0, y_i} < ({1'b0, pos_y_q[i]} + SizeP));
      dx[i] = x_i - pos_x_q[i];
      dy[i] = y_i - pos_y_q[i];
      spr_addr_d[i] = hit_d[i] ? {dy[i][SW-1:0], dx[i][SW-1:0]} : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Hit/active delay line, aligned with the RAM read data
  // ---------------------------------------------------------------------------
  // Entry 0 is the stage-0 register; entry MEM_LATENCY lines up with spr_color_i.
  logic [NUM_SPRITES-1:0] hit_pipe_q [MEM_LATENCY+1];
  logic [MEM_LATENCY:0]   act_pipe_q;

  // Stage-0 registers plus the MEM_LATENCY-deep alignment shift.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        spr_addr_q[i] <= '0;
      end
      for (int k = 0; k <= MEM_LATENCY; k++) begin
        hit_pipe_q[k] <= '0;
      end
      act_pipe_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        spr_addr_q[i] <= spr_addr_d[i];
      end
      hit_pipe_q[0] <= hit_d;
      act_pipe_q[0] <= active_i;
      for (int k = 1; k <= MEM_LATENCY; k++) begin
        hit_pipe_q[k] <= hit_pipe_q[k-1];
        act_pipe_q[k] <= act_pipe_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Final stage: transparency, priority and blanking
  // ---------------------------------------------------------------------------
  logic [NUM_SPRITES-1:0] hit_al;
  logic                   act_al;
  logic [NUM_SPRITES-1:0] opaque;
  logic [11:0]            colour;
  logic [11:0]            vga_rgb_d;
  logic [11:0]            vga_rgb_q;

  assign hit_al = hit_pipe_q[MEM_LATENCY];
  assign act_al = act_pipe_q[MEM_LATENCY];

  // Walk from lowest priority up so the lowest-index opaque sprite wins.
  always_comb begin
    colour = bg_color_i;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      opaque[i] = hit_al[i] && (spr_color_i[i*12 +: 12] != TRANSPARENT_KEY);
      if (opaque[i]) begin
        colour = spr_color_i[i*12 +: 12];
      end
    end
    vga_rgb_d = act_al ? colour : 12'h000;
  end

  // Registered pixel output.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      vga_rgb_q <= 12'h000;
    end else begin
      vga_rgb_q <= vga_rgb_d;
    end
  end

  assign vga_rgb_o = vga_rgb_q;

  // ---------------------------------------------------------------------------
  // Optional collision detection
  // ---------------------------------------------------------------------------
`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] coll_hit;
  logic [NUM_SPRITES-1:0] coll_acc_d;
  logic [NUM_SPRITES-1:0] coll_acc_q;
  logic [NUM_SPRITES-1:0] collide_mask_d;
  logic [NUM_SPRITES-1:0] collide_mask_q;
  logic [NUM_SPRITES-1:0] others;

  // A sprite collides when it and at least one other sprite are opaque on a visible pixel.
  always_comb begin
    others = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      others    = opaque;
      others[i] = 1'b0;
      coll_hit[i] = act_al && opaque[i] && (|others);
    end
    coll_acc_d     = tick ? '0 : (coll_acc_q | coll_hit);
    collide_mask_d = tick ? (coll_acc_q | coll_hit) : collide_mask_q;
  end

  // Accumulate over a frame, publish at the tick and hold for the next frame.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      coll_acc_q     <= '0;
      collide_mask_q <= '0;
    end else begin
      coll_acc_q     <= coll_acc_d;
      collide_mask_q <= collide_mask_d;
    end
  end

  assign collide_mask_o = collide_mask_q;
`else
  assign collide_mask_o = '0;
`endif

  // ---------------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign spr_addr_o[g*AW +: AW] = spr_addr_q[g];
    assign pos_x_o[g*10 +: 10]    = pos_x_q[g];
    assign pos_y_o[g*10 +: 10]    = pos_y_q[g];
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Testbench for sprite_compositor (default parameters: 2 sprites, 64x64, step 3,
// MEM_LATENCY 2). The external image RAM is modelled as a delay line that returns the
// colours requested for a pixel MEM_LATENCY cycles after the address appears.
module tb_sprite_compositor;

  localparam int N  = 2;
  localparam int ML = 2;
  localparam int AW = 12;
  localparam int L  = ML + 2;

`ifdef SPRITE_COLLISION_EN
  localparam logic [N-1:0] ExpColl = 2'b11;
`else
  localparam logic [N-1:0] ExpColl = 2'b00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic [9:0]      x, y;
  logic            active, screen_end;
  logic [N-1:0]    mu, md, mleft, mright;
  logic [N*AW-1:0] spr_addr;
  logic [N*12-1:0] spr_color;
  logic [11:0]     bg_color, vga_rgb;
  logic [N*10-1:0] pos_x, pos_y;
  logic [N-1:0]    collide_mask;

  sprite_compositor dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .x_i            (x),
    .y_i            (y),
    .active_i       (active),
    .screen_end_i   (screen_end),
    .move_up_i      (mu),
    .move_down_i    (md),
    .move_left_i    (mleft),
    .move_right_i   (mright),
    .spr_addr_o     (spr_addr),
    .spr_color_i    (spr_color),
    .bg_color_i     (bg_color),
    .vga_rgb_o      (vga_rgb),
    .pos_x_o        (pos_x),
    .pos_y_o        (pos_y),
    .collide_mask_o (collide_mask)
  );

  // RAM model: colours requested with a pixel come back ML cycles after its address.
  logic [11:0] req_c0, req_c1, req_bg;
  logic [35:0] cpipe [ML+1];
  always @(posedge clk) begin
    cpipe[0] <= {req_c1, req_c0, req_bg};
    for (int k = 1; k <= ML; k++) cpipe[k] <= cpipe[k-1];
  end
  assign spr_color = cpipe[ML][35:12];
  assign bg_color  = cpipe[ML][11:0];

  typedef struct {
    logic [9:0]    x, y;
    logic          act;
    logic [11:0]   c0, c1, bg, exp_rgb;
    logic [AW-1:0] exp_a0, exp_a1;
  } vec_t;
  typedef struct { int due; logic [11:0] rgb; } rq_t;
  typedef struct { int due; logic [AW-1:0] a0, a1; } aq_t;

  vec_t tbl[$];
  rq_t  rq[$];
  aq_t  aq[$];
  int   n_tests, n_fail, cyc;
  int   pm_x[N], pm_y[N];

  function automatic vec_t mk(input int vx, input int vy, input logic a,
                              input logic [11:0] c0, input logic [11:0] c1,
                              input logic [11:0] bg, input logic [11:0] er,
                              input int a0, input int a1);
    vec_t v;
    v.x = 10'(vx); v.y = 10'(vy); v.act = a;
    v.c0 = c0; v.c1 = c1; v.bg = bg; v.exp_rgb = er;
    v.exp_a0 = AW'(a0); v.exp_a1 = AW'(a1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drain_due();
    rq_t r;
    aq_t a;
    while (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      chk($sformatf("rgb@%0d", cyc), 32'(vga_rgb), 32'(r.rgb));
    end
    while (aq.size() > 0 && aq[0].due == cyc) begin
      a = aq.pop_front();
      chk($sformatf("addr0@%0d", cyc), 32'(spr_addr[AW-1:0]), 32'(a.a0));
      chk($sformatf("addr1@%0d", cyc), 32'(spr_addr[2*AW-1:AW]), 32'(a.a1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drain_due();
  endtask

  task automatic run_table();
    foreach (tbl[k]) begin
      x = tbl[k].x; y = tbl[k].y; active = tbl[k].act;
      req_c0 = tbl[k].c0; req_c1 = tbl[k].c1; req_bg = tbl[k].bg;
      rq.push_back('{due: cyc + L, rgb: tbl[k].exp_rgb});
      aq.push_back('{due: cyc + 1, a0: tbl[k].exp_a0, a1: tbl[k].exp_a1});
      step();
    end
    active = 1'b0;
    for (int w = 0; w < 20 && (rq.size() > 0 || aq.size() > 0); w++) step();
    chk("drain", 32'(rq.size() + aq.size()), 32'd0);
    rq.delete();
    aq.delete();
    tbl.delete();
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      pm_x[i] = 16 + i * 128;
      pm_y[i] = 16;
    end
  endfunction

  task automatic tick(input logic [N-1:0] u, input logic [N-1:0] d,
                      input logic [N-1:0] l, input logic [N-1:0] r);
    mu = u; md = d; mleft = l; mright = r;
    screen_end = 1'b1;
    step();
    step();
    screen_end = 1'b0;
    step();
    mu = '0; md = '0; mleft = '0; mright = '0;
    for (int i = 0; i < N; i++) begin
      if (r[i] && !l[i] && pm_x[i] + 64 + 3 < 640) pm_x[i] += 3;
      else if (l[i] && !r[i] && pm_x[i] >= 3) pm_x[i] -= 3;
      if (d[i] && !u[i] && pm_y[i] + 64 + 3 < 480) pm_y[i] += 3;
      else if (u[i] && !d[i] && pm_y[i] >= 3) pm_y[i] -= 3;
    end
  endtask

  task automatic check_pos(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_px%0d", tag, i), 32'(pos_x[i*10 +: 10]), 32'(pm_x[i]));
      chk($sformatf("%s_py%0d", tag, i), 32'(pos_y[i*10 +: 10]), 32'(pm_y[i]));
    end
  endtask

  task automatic move_to(input int tx0, input int ty0, input int tx1, input int ty1);
    logic [N-1:0] u, d, l, r;
    int tx[N], ty[N];
    tx[0] = tx0; ty[0] = ty0; tx[1] = tx1; ty[1] = ty1;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        r[i] = pm_x[i] < tx[i]; l[i] = pm_x[i] > tx[i];
        d[i] = pm_y[i] < ty[i]; u[i] = pm_y[i] > ty[i];
      end
      if ((u | d | l | r) == '0) break;
      tick(u, d, l, r);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    resetn = 1'b0; x = '0; y = '0; active = 1'b0; screen_end = 1'b0;
    mu = '0; md = '0; mleft = '0; mright = '0;
    req_c0 = '0; req_c1 = '0; req_bg = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(vga_rgb), 32'd0);
    chk("rst_addr", 32'(spr_addr), 32'd0);
    chk("rst_coll", 32'(collide_mask), 32'd0);
    chk("rst_pos_x", 32'(pos_x), 32'({10'd144, 10'd16}));
    chk("rst_pos_y", 32'(pos_y), 32'({10'd16, 10'd16}));
    resetn = 1'b1;

    // Idle frames: nothing moves, blanked output stays black.
    repeat (3) tick('0, '0, '0, '0);
    check_pos("idle");
    chk("idle_rgb", 32'(vga_rgb), 32'd0);

    // Pixel stream at reset positions: sprite0 (16,16), sprite1 (144,16).
    tbl.push_back(mk(20, 20, 1, 12'h0A0, 12'h00F, 12'h123, 12'h0A0, 260, 0));
    tbl.push_back(mk(20, 20, 0, 12'h0A0, 12'h00F, 12'h123, 12'h000, 260, 0));
    tbl.push_back(mk(150, 30, 1, 12'h0A0, 12'h00F, 12'h123, 12'h00F, 0, 902));
    tbl.push_back(mk(150, 30, 1, 12'h0A0, 12'hF0F, 12'h123, 12'h123, 0, 902));
    tbl.push_back(mk(300, 300, 1, 12'h0A0, 12'h00F, 12'h456, 12'h456, 0, 0));
    tbl.push_back(mk(15, 16, 1, 12'h0A0, 12'h00F, 12'h111, 12'h111, 0, 0));
    tbl.push_back(mk(16, 16, 1, 12'h0A0, 12'h00F, 12'h111, 12'h0A0, 0, 0));
    tbl.push_back(mk(79, 79, 1, 12'h0A0, 12'h00F, 12'h111, 12'h0A0, 4095, 0));
    tbl.push_back(mk(80, 79, 1, 12'h0A0, 12'h00F, 12'h111, 12'h111, 0, 0));
    tbl.push_back(mk(79, 80, 1, 12'h0A0, 12'h00F, 12'h111, 12'h111, 0, 0));
    tbl.push_back(mk(16, 16, 1, 12'hF0F, 12'h00F, 12'h222, 12'h222, 0, 0));
    tbl.push_back(mk(207, 79, 1, 12'h0A0, 12'hABC, 12'h333, 12'hABC, 0, 4095));
    tbl.push_back(mk(208, 20, 1, 12'h0A0, 12'hABC, 12'h333, 12'h333, 0, 0));
    tbl.push_back(mk(143, 16, 1, 12'h0A0, 12'hABC, 12'h444, 12'h444, 0, 0));
    run_table();

    // Motion and edge guards.
    repeat (10) tick('0, '0, '0, 2'b01);
    chk("right10_px0", 32'(pos_x[9:0]), 32'd46);
    repeat (143) tick('0, '0, '0, 2'b10);
    chk("edge_px1", 32'(pos_x[19:10]), 32'd573);
    tick('0, '0, '0, 2'b10);
    chk("edge_hold_px1", 32'(pos_x[19:10]), 32'd573);
    tick(2'b11, 2'b11, 2'b11, 2'b11);
    check_pos("both_dirs");
    repeat (16) tick(2'b01, '0, 2'b01, '0);
    chk("left_px0", 32'(pos_x[9:0]), 32'd1);
    chk("up_py0", 32'(pos_y[9:0]), 32'd1);
    repeat (140) tick('0, 2'b10, '0, '0);
    chk("bottom_py1", 32'(pos_y[19:10]), 32'd415);
    check_pos("edges");

    // Overlap sprite0 at (100,100) with sprite1 at (99,100).
    move_to(100, 100, 99, 100);
    check_pos("overlap");
    tbl.push_back(mk(120, 120, 1, 12'h0A0, 12'h00F, 12'h123, 12'h0A0, 1300, 1301));
    tbl.push_back(mk(120, 120, 1, 12'hF0F, 12'h00F, 12'h123, 12'h00F, 1300, 1301));
    tbl.push_back(mk(120, 120, 1, 12'hF0F, 12'hF0F, 12'h123, 12'h123, 1300, 1301));
    tbl.push_back(mk(99, 100, 1, 12'h0A0, 12'h00F, 12'h555, 12'h00F, 0, 0));
    tbl.push_back(mk(163, 100, 1, 12'h0A0, 12'h00F, 12'h555, 12'h0A0, 63, 0));
    run_table();
    tick('0, '0, '0, '0);
    chk("coll_set", 32'(collide_mask), 32'(ExpColl));

    // Next frame: overlap only while blanked or with one side transparent.
    tbl.push_back(mk(120, 120, 0, 12'h0A0, 12'h00F, 12'h123, 12'h000, 1300, 1301));
    tbl.push_back(mk(120, 120, 1, 12'h0A0, 12'hF0F, 12'h123, 12'h0A0, 1300, 1301));
    run_table();
    chk("coll_hold", 32'(collide_mask), 32'(ExpColl));
    tick('0, '0, '0, '0);
    chk("coll_clear", 32'(collide_mask), 32'd0);

    // Mid-frame reset with an active opaque pixel in flight.
    x = 10'd120; y = 10'd120; active = 1'b1;
    req_c0 = 12'h0A0; req_c1 = 12'h00F; req_bg = 12'h123;
    repeat (5) step();
    chk("pre_rst_rgb", 32'(vga_rgb), 32'h0A0);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_rgb", 32'(vga_rgb), 32'd0);
    chk("mid_rst_addr", 32'(spr_addr), 32'd0);
    chk("mid_rst_coll", 32'(collide_mask), 32'd0);
    check_pos("mid_rst");
    x = 10'd20; y = 10'd20;
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= L; k++) begin
      step();
      if (k == 1) chk("post_rst_addr0", 32'(spr_addr[AW-1:0]), 32'd260);
      chk($sformatf("post_rst_rgb%0d", k), 32'(vga_rgb), (k == L) ? 32'h0A0 : 32'h000);
    end
    active = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
